// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared constants and byte-lane mask helper for data_mem
package data_mem_pkg;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 64;
    localparam int IDX_W  = $clog2(DEPTH);

    // Bit 0 enables the low byte, bit 1 the high byte.
    function automatic logic [1:0] lane_mask(input logic sb, input logic lane);
        if (!sb) begin
            return 2'b11;
        end
        return lane ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/data_mem_lane_dec.sv
// rtl/data_mem_lane_dec.sv - per-lane write enable decoder
module data_mem_lane_dec
    import data_mem_pkg::*;
(
    input  logic       w,
    input  logic       sb,
    input  logic       lane,
    output logic [1:0] lane_we
);

    always_comb begin
        lane_we = 2'b00;
        if (w) begin
            lane_we = lane_mask(sb, lane);
        end
    end

endmodule

// File: rtl/data_mem.sv
// rtl/data_mem.sv - 16-bit byte-addressable data memory with registered read and debug taps
module data_mem #(
    parameter int DATA_W = data_mem_pkg::DATA_W,
    parameter int DEPTH  = data_mem_pkg::DEPTH,
    parameter int IDX_W  = data_mem_pkg::IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w,
    input  logic              r,
    input  logic              sb,
    input  logic [15:0]       wa,
    input  logic [15:0]       wd,
    output logic [DATA_W-1:0] rd,
    output logic [DATA_W-1:0] m0,
    output logic [DATA_W-1:0] m1,
    output logic [DATA_W-1:0] m2,
    output logic [DATA_W-1:0] m3,
    output logic [DATA_W-1:0] m4
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] rd_d;

    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane_we;
    logic [15:0]       wr_word;
    logic              unused_hi_addr;

    // Upper address bits are dropped so out-of-range addresses wrap.
    assign idx            = wa[IDX_W:1];
    assign unused_hi_addr = ^wa[15:IDX_W+1];

    // A byte store replicates the low data byte so either lane can take it.
    assign wr_word = sb ? {wd[7:0], wd[7:0]} : wd;

    data_mem_lane_dec u_lane_dec (
        .w       (w),
        .sb      (sb),
        .lane    (wa[0]),
        .lane_we (lane_we)
    );

    always_comb begin
        mem_d = mem_q;
        if (lane_we[0]) begin
            mem_d[idx][7:0] = wr_word[7:0];
        end
        if (lane_we[1]) begin
            mem_d[idx][15:8] = wr_word[15:8];
        end
    end

    // Reads sample the pre-write array, giving read-before-write on a collision.
    always_comb begin
        rd_d = rd_q;
        if (r) begin
            rd_d = mem_q[idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
        end
    end

    assign rd = rd_q;
    assign m0 = mem_q[0];
    assign m1 = mem_q[1];
    assign m2 = mem_q[2];
    assign m3 = mem_q[3];
    assign m4 = mem_q[4];

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - scoreboard testbench for data_mem
module tb_data_mem;

    typedef struct {
        logic [15:0] rd;
        logic [15:0] m [5];
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        w = 1'b0;
    logic        r = 1'b0;
    logic        sb = 1'b0;
    logic [15:0] wa = '0;
    logic [15:0] wd = '0;
    logic [15:0] rd, m0, m1, m2, m3, m4;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t exp_q[$];
    int   model_mem [64];
    int   model_rd;

    data_mem dut (
        .clk   (clk),
        .reset (reset),
        .w     (w),
        .r     (r),
        .sb    (sb),
        .wa    (wa),
        .wd    (wd),
        .rd    (rd),
        .m0    (m0),
        .m1    (m1),
        .m2    (m2),
        .m3    (m3),
        .m4    (m4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model_mem[i] = 0;
        model_rd = 0;
    endtask

    // Drive one request for the next rising edge and queue the model's post-edge view.
    task automatic op(input logic ow, input logic orr, input logic osb,
                      input logic [15:0] owa, input logic [15:0] owd);
        int   i;
        int   b;
        exp_t e;
        @(negedge clk);
        w = ow; r = orr; sb = osb; wa = owa; wd = owd;
        i = (int'(owa) / 2) % 64;
        b = int'(owd) % 256;
        if (orr) model_rd = model_mem[i];
        if (ow) begin
            if (!osb)          model_mem[i] = int'(owd);
            else if (owa[0])   model_mem[i] = (model_mem[i] % 256) + b * 256;
            else               model_mem[i] = (model_mem[i] / 256) * 256 + b;
        end
        e.rd = 16'(model_rd);
        for (int k = 0; k < 5; k++) e.m[k] = 16'(model_mem[k]);
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd", rd, e.rd);
            check("m0", m0, e.m[0]);
            check("m1", m1, e.m[1]);
            check("m2", m2, e.m[2]);
            check("m3", m3, e.m[3]);
            check("m4", m4, e.m[4]);
        end
    end

    initial begin
        model_clear();
        // Power-up reset with a write pending; outputs must clear without a clock.
        w = 1'b1; wa = 16'h0000; wd = 16'hdead;
        #1 reset = 1'b1;
        #1;
        check("reset_rd", rd, 16'h0000);
        check("reset_m0", m0, 16'h0000);
        @(posedge clk); @(posedge clk); #1;
        check("reset_hold_m0", m0, 16'h0000);
        @(negedge clk);
        w = 1'b0;
        reset = 1'b0;

        op(1, 0, 0, 16'h0004, 16'h1234);
        op(0, 1, 0, 16'h0004, 16'h0000);
        op(1, 0, 0, 16'h003c, 16'h0000);
        op(1, 0, 1, 16'hacbd, 16'h0001);
        op(0, 1, 1, 16'hacbc, 16'h0000);
        op(1, 0, 0, 16'h0002, 16'hffff);
        op(1, 0, 1, 16'h0002, 16'hab55);
        op(1, 0, 0, 16'h0000, 16'h1111);
        op(1, 1, 0, 16'h0000, 16'h2222);
        op(0, 1, 0, 16'h0000, 16'h0000);
        op(1, 0, 0, 16'h0080, 16'hbeef);
        for (int k = 0; k < 4; k++) op(0, 0, 0, 16'(k * 2), 16'hffff);

        for (int k = 0; k < 400; k++) begin
            logic [15:0] a;
            a = 16'($urandom);
            if ($urandom_range(0, 1) == 1) a = 16'($urandom_range(0, 11));
            op(1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom));
        end

        // Mid-run reset with a write pending clears the array immediately.
        op(1, 0, 0, 16'h0006, 16'h5a5a);
        op(0, 1, 0, 16'h0006, 16'h0000);
        @(negedge clk);
        w = 1'b1; r = 1'b1; sb = 1'b0; wa = 16'h0008; wd = 16'h7777;
        reset = 1'b1;
        #1;
        check("midreset_rd", rd, 16'h0000);
        check("midreset_m3", m3, 16'h0000);
        check("midreset_m4", m4, 16'h0000);
        @(posedge clk); #1;
        check("midreset_write_blocked", m4, 16'h0000);
        @(negedge clk);
        w = 1'b0; r = 1'b0;
        reset = 1'b0;
        model_clear();
        op(0, 1, 0, 16'h0006, 16'h0000);
        op(1, 0, 1, 16'h0009, 16'h00c3);
        op(0, 1, 0, 16'h0008, 16'h0000);
        op(0, 0, 0, 16'h0000, 16'h0000);

        repeat (3) @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem.md
# data_mem

Single-port, byte-addressable data memory for the CPU datapath, sitting behind the execute stage for load/store instructions. It stores 16-bit words and supports full-word stores and byte stores into a selected lane. It provides registered reads and continuously exports words 0–4 as debug taps (m0–m4) for waveform and monitor visibility.

## Interface

Parameters:
- DATA_W, default 16: word width. Fixed at 16; the byte-store logic assumes two 8-bit lanes.
- DEPTH, default 64: number of words. Must be a power of two.
- IDX_W, default log2(DEPTH) = 6: word-index width.

Ports:
- clk, input, 1: single clock. All sequential logic updates on the rising edge.
- reset, input, 1: reset is asynchronous and active-high. It clears every memory word and rd to 0.
- w, input, 1: write enable.
- r, input, 1: read enable.
- sb, input, 1: store-byte qualifier. Meaningful only when w=1.
- wa, input, 16: byte address, shared by reads and writes.
  - wa[0] is the byte lane.
  - wa[IDX_W:1] is the word index.
  - wa[15:IDX_W+1] is ignored.
- wd, input, 16: write data.
- rd, output, 16: registered read data.
- m0..m4, output, 16 each: combinational views of words 0..4.

## Operation

- Word index: idx = wa[IDX_W:1]. Higher address bits are dropped, so out-of-range addresses alias (wrap) into the array without error.
- Write with w=1, sb=0, at a rising edge: mem[idx] <= wd. wa[0] is ignored.
- Write with w=1, sb=1 (byte store), at a rising edge: only the lane selected by wa[0] is written; the other byte is preserved.
  - wa[0]=0: mem[idx][7:0] <= wd[7:0].
  - wa[0]=1: mem[idx][15:8] <= wd[7:0].
- With w=0, no write occurs, regardless of sb.
- Read with r=1, at a rising edge: rd <= mem[idx], the full word. sb does not affect reads.
- With r=0, rd holds its last value.
- Read and write in the same cycle to the same index: read-before-write. rd receives the pre-write word; the new data is visible on the following read.
- m0..m4 are mem[0]..mem[4], driven combinationally from the array. A write to words 0–4 is visible on the taps immediately after the write edge.
- X/undriven sb while w=1 is an illegal input. The design does not need to handle it gracefully.

## Timing

- Reset is asynchronous. When reset=1, rd, all memory words and m0..m4 read 0 without waiting for a clock edge.
- While reset is held, writes and reads are suppressed.
- The first active edge is the first rising clk edge after reset deasserts.
- Write latency: the data is in the array at the edge where w=1. A tap update appears within the same cycle, after that edge.
- Read latency: 1 cycle. The address and r are sampled at edge N; rd is valid after edge N and is stable until the next edge with r=1.
- No handshake: every request completes in one cycle and there is no busy or stall signal.
- Reset asserted in the middle of operation aborts any write at that edge and clears the array.

## Structure

- Shared package data_mem_pkg holds:
  - DATA_W, DEPTH and IDX_W constants.
  - A function returning the 2-bit byte-lane write mask from {sb, wa[0]}: 11 for a word store, 01 for lane 0, 10 for lane 1.
- One sub-module is natural: data_mem_lane_dec, a purely combinational decoder taking w, sb and wa[0] and producing a per-lane write enable.
- The top level holds the array, the read register and the tap assignments.

## Test plan

- Reset clears: assert reset, write stimulus pending -> rd=0000 and m0..m4=0000 immediately; no array change while reset=1.
- Word write/read: w=1, sb=0, wa=0004, wd=1234; then r=1, wa=0004 -> m2=1234; rd=1234 one cycle after the read edge.
- Byte store high lane: preload word index 30 with 0000; then w=1, sb=1, wa=acbd (idx=30, lane 1), wd=0001 -> mem[30]=0100. A read of wa=acbc gives rd=0100.
- Byte store low lane: preload mem[1]=ffff; then w=1, sb=1, wa=0002, wd=ab55 -> m1=ff55.
- Read-before-write: mem[0]=1111; same-edge r=1, w=1, wa=0000, wd=2222 -> rd=1111, m0=2222. The next read gives rd=2222.
- Aliasing and hold: write wd=beef at wa=0080 (idx 0) -> m0=beef. With r=0 for several cycles, rd is unchanged.
